// File: rtl/pll_rst_seq.sv
// PLL power-on/reset sequencer: pulses the PLL reset, qualifies lock,
// then releases chip and peripheral resets in order, with retry and fail.
module pll_rst_seq #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 64,
    parameter int LOCK_TIMEOUT_CYCLES = 4096,
    parameter int RELEASE_GAP         = 8,
    parameter int MAX_RETRY           = 3,
    parameter int CNT_W               = 16,
    parameter int RETRY_W             = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               locked,
    input  logic               sw_reset_req,
    output logic               pll_areset,
    output logic               chip_reset,
    output logic               periph_reset,
    output logic               rst_done,
    output logic               pll_fail,
    output logic [RETRY_W-1:0] retry_cnt
);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_REL_CHIP,
        S_RUN,
        S_FAIL
    } state_t;

    localparam logic [CNT_W-1:0] TIMER_MAX = '1;
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(RELEASE_GAP - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               sync1_q, sync2_q;
    logic               locked_s;

    logic pll_areset_q, pll_areset_d;
    logic chip_reset_q, chip_reset_d;
    logic periph_reset_q, periph_reset_d;
    logic rst_done_q, rst_done_d;
    logic pll_fail_q, pll_fail_d;

    assign locked_s = sync2_q;

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        timer_d = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;
        if (sw_reset_req) begin
            state_d = S_PLL_RST;
            retry_d = '0;
        end else if (!locked_s &&
                     (state_q == S_REL_CHIP || state_q == S_RUN)) begin
            state_d = S_PLL_RST;
            retry_d = '0;
        end else begin
            unique case (state_q)
                S_PLL_RST: begin
                    if (timer_q == RST_LAST) state_d = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    // a lock seen on the timeout cycle still counts
                    if (locked_s) begin
                        state_d = S_STABLE;
                    end else if (timer_q == TMO_LAST) begin
                        if (retry_q == RETRY_MAX) begin
                            state_d = S_FAIL;
                        end else begin
                            state_d = S_PLL_RST;
                            retry_d = retry_q + 1'b1;
                        end
                    end
                end
                S_STABLE: begin
                    if (!locked_s) state_d = S_WAIT_LOCK;
                    else if (timer_q == STB_LAST) state_d = S_REL_CHIP;
                end
                S_REL_CHIP: begin
                    if (timer_q == GAP_LAST) state_d = S_RUN;
                end
                S_RUN, S_FAIL: begin
                    state_d = state_q;
                end
                default: state_d = S_PLL_RST;
            endcase
        end
        if (sw_reset_req || state_d != state_q) timer_d = '0;
    end

    always_comb begin
        pll_areset_d   = 1'b1;
        chip_reset_d   = 1'b1;
        periph_reset_d = 1'b1;
        rst_done_d     = 1'b0;
        pll_fail_d     = 1'b0;
        unique case (state_q)
            S_WAIT_LOCK, S_STABLE: begin
                pll_areset_d = 1'b0;
            end
            S_REL_CHIP: begin
                pll_areset_d = 1'b0;
                chip_reset_d = 1'b0;
            end
            S_RUN: begin
                pll_areset_d   = 1'b0;
                chip_reset_d   = 1'b0;
                periph_reset_d = 1'b0;
                rst_done_d     = 1'b1;
            end
            S_FAIL: begin
                pll_fail_d = 1'b1;
            end
            default: begin
                pll_areset_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_PLL_RST;
            timer_q        <= '0;
            retry_q        <= '0;
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            pll_areset_q   <= 1'b1;
            chip_reset_q   <= 1'b1;
            periph_reset_q <= 1'b1;
            rst_done_q     <= 1'b0;
            pll_fail_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            retry_q        <= retry_d;
            sync1_q        <= locked;
            sync2_q        <= sync1_q;
            pll_areset_q   <= pll_areset_d;
            chip_reset_q   <= chip_reset_d;
            periph_reset_q <= periph_reset_d;
            rst_done_q     <= rst_done_d;
            pll_fail_q     <= pll_fail_d;
        end
    end

    assign pll_areset   = pll_areset_q;
    assign chip_reset   = chip_reset_q;
    assign periph_reset = periph_reset_q;
    assign rst_done     = rst_done_q;
    assign pll_fail     = pll_fail_q;
    assign retry_cnt    = retry_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Bench for pll_rst_seq: directed sequence plus random lock/sw traffic,
// checked every cycle against a phase/age reference model.
module tb_pll_rst_seq;

    localparam int PRC = 16;
    localparam int LSC = 64;
    localparam int LTC = 4096;
    localparam int RG  = 8;
    localparam int MR  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       locked = 1'b0;
    logic       sw_reset_req = 1'b0;
    logic       pll_areset, chip_reset, periph_reset, rst_done, pll_fail;
    logic [1:0] retry_cnt;

    pll_rst_seq #(
        .PLL_RST_CYCLES(PRC), .LOCK_STABLE_CYCLES(LSC),
        .LOCK_TIMEOUT_CYCLES(LTC), .RELEASE_GAP(RG),
        .MAX_RETRY(MR), .CNT_W(16), .RETRY_W(2)
    ) dut (
        .clk(clk), .reset(reset), .locked(locked),
        .sw_reset_req(sw_reset_req), .pll_areset(pll_areset),
        .chip_reset(chip_reset), .periph_reset(periph_reset),
        .rst_done(rst_done), .pll_fail(pll_fail), .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    localparam int M_RST = 0, M_WAIT = 1, M_STAB = 2;
    localparam int M_REL = 3, M_RUN = 4, M_FAIL = 5;

    int ph, age, tries;
    bit ls1, ls2;
    logic [6:0] exp_o;
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // {pll_areset, chip_reset, periph_reset, rst_done, pll_fail}
    function automatic logic [4:0] look(input int p);
        logic [4:0] r;
        r[4] = (p == M_RST) || (p == M_FAIL);
        r[3] = !((p == M_REL) || (p == M_RUN));
        r[2] = (p != M_RUN);
        r[1] = (p == M_RUN);
        r[0] = (p == M_FAIL);
        return r;
    endfunction

    task automatic enter(input int p);
        ph  = p;
        age = 0;
    endtask

    task automatic model_edge();
        logic [4:0] seen;
        bit ls;
        if (reset) begin
            enter(M_RST);
            tries = 0;
            ls1 = 0;
            ls2 = 0;
            exp_o = {look(M_RST), 2'd0};
            return;
        end
        seen = look(ph);
        ls = ls2;
        ls2 = ls1;
        ls1 = locked;
        if (sw_reset_req) begin
            enter(M_RST);
            tries = 0;
        end else if ((ph == M_REL || ph == M_RUN) && !ls) begin
            enter(M_RST);
            tries = 0;
        end else begin
            case (ph)
                M_RST: begin
                    age++;
                    if (age == PRC) enter(M_WAIT);
                end
                M_WAIT: begin
                    if (ls) enter(M_STAB);
                    else begin
                        age++;
                        if (age == LTC) begin
                            if (tries == MR) enter(M_FAIL);
                            else begin
                                tries++;
                                enter(M_RST);
                            end
                        end
                    end
                end
                M_STAB: begin
                    if (!ls) enter(M_WAIT);
                    else begin
                        age++;
                        if (age == LSC) enter(M_REL);
                    end
                end
                M_REL: begin
                    age++;
                    if (age == RG) enter(M_RUN);
                end
                default: ;
            endcase
        end
        exp_o = {seen, 2'(tries)};
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d obs=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {pll_areset, chip_reset, periph_reset,
                rst_done, pll_fail, retry_cnt};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        chk("outs", {25'd0, outs()}, {25'd0, exp_o});
    endtask

    task automatic run_meas(input int n, output int t_pa, output int t_cr,
                            output int t_pr, output int t_dn);
        t_pa = -1; t_cr = -1; t_pr = -1; t_dn = -1;
        for (int i = 0; i < n; i++) begin
            step();
            if (t_pa < 0 && !pll_areset) t_pa = i;
            if (t_cr < 0 && !chip_reset) t_cr = i;
            if (t_pr < 0 && !periph_reset) t_pr = i;
            if (t_dn < 0 && rst_done) t_dn = i;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
        chk("rst_vals", {25'd0, outs()}, 32'b1110000);
        reset = 1'b0;
    endtask

    initial begin
        int a, b, c, d;
        int t_f, t_r1, t_r2, t_r3;

        // nominal bring-up with lock already present
        locked = 1'b1;
        do_reset(3);
        run_meas(120, a, b, c, d);
        chk("pa_fall", a, 16);
        chk("chip_fall", b, 81);
        chk("periph_fall", c, 89);
        chk("done_rise", d, 89);
        chk("retry_run", retry_cnt, 0);

        // lock loss in RUN restarts from PLL_RST
        locked = 1'b0;
        step();
        locked = 1'b1;
        step();
        step();
        chk("done_hold", rst_done, 1);
        step();
        chk("rearm", {pll_areset, chip_reset, periph_reset, rst_done}, 4'b1110);
        run_meas(120, a, b, c, d);
        chk("rerun_done", rst_done, 1);
        chk("rerun_retry", retry_cnt, 0);

        // one-cycle lock glitch at STABLE count 40
        do_reset(1);
        repeat (54) step();
        locked = 1'b0;
        step();
        locked = 1'b1;
        run_meas(150, a, b, c, d);
        chk("glitch_chip", b + 55, 122);
        chk("glitch_periph", c + 55, 130);
        chk("glitch_retry", retry_cnt, 0);

        // sw request during REL_CHIP
        do_reset(1);
        repeat (84) step();
        chk("in_rel", {chip_reset, periph_reset}, 2'b01);
        sw_reset_req = 1'b1;
        step();
        sw_reset_req = 1'b0;
        step();
        chk("sw_rel", {25'd0, outs()}, 32'b1110000);
        repeat (100) step();

        // lock never arrives: four attempts, then FAIL
        locked = 1'b0;
        do_reset(1);
        t_f = -1; t_r1 = -1; t_r2 = -1; t_r3 = -1;
        for (int i = 0; i < 16460; i++) begin
            step();
            if (t_r1 < 0 && retry_cnt == 2'd1) t_r1 = i;
            if (t_r2 < 0 && retry_cnt == 2'd2) t_r2 = i;
            if (t_r3 < 0 && retry_cnt == 2'd3) t_r3 = i;
            if (t_f < 0 && pll_fail) t_f = i;
        end
        chk("retry1_t", t_r1, 4111);
        chk("retry2_t", t_r2, 8223);
        chk("retry3_t", t_r3, 12335);
        chk("fail_t", t_f, 16448);
        chk("fail_pa", pll_areset, 1);
        chk("fail_retry", retry_cnt, 3);
        sw_reset_req = 1'b1;
        step();
        chk("sw_fail_retry", retry_cnt, 0);
        sw_reset_req = 1'b0;
        step();
        chk("sw_fail_clr", {pll_fail, pll_areset}, 2'b01);

        // sw request in WAIT_LOCK with two retries used, then held high
        repeat (8300) step();
        chk("wait_retry2", retry_cnt, 2);
        sw_reset_req = 1'b1;
        step();
        chk("sw_wait_retry", retry_cnt, 0);
        repeat (30) step();
        chk("sw_held", {25'd0, outs()}, 32'b1110000);
        sw_reset_req = 1'b0;
        locked = 1'b1;
        run_meas(120, a, b, c, d);
        chk("after_sw_done", b + 31, 112);
        chk("after_sw_run", rst_done, 1);

        // reset pulse mid-STABLE restarts the nominal timing
        do_reset(1);
        repeat (50) step();
        do_reset(1);
        run_meas(120, a, b, c, d);
        chk("rr_pa", a, 16);
        chk("rr_chip", b, 81);
        chk("rr_periph", c, 89);

        // random lock arrival, glitches and sw requests
        for (int r = 0; r < 8; r++) begin
            locked = 1'b0;
            do_reset(1);
            repeat ($urandom_range(0, 300)) step();
            for (int i = 0; i < 500; i++) begin
                locked = ($urandom_range(0, 63) != 0);
                sw_reset_req = ($urandom_range(0, 255) == 0);
                step();
            end
            sw_reset_req = 1'b0;
            locked = 1'b1;
            repeat (120) step();
            chk("rand_settle", rst_done, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pll_rst_seq.md
Name: pll_rst_seq

Overview:
- Power-on and reset sequencer for the clock-generation PLL.
- Runs on the free-running reference clock.
- Pulses the PLL's asynchronous reset, waits for a stable lock, then releases chip and peripheral resets in order.
- Retries a PLL that fails to lock, flags a permanent failure, and restarts the whole sequence on lock loss or a software reset request.

Parameters:
- PLL_RST_CYCLES, 16, cycles pll_areset is held high per attempt (≥1)
- LOCK_STABLE_CYCLES, 64, consecutive cycles synchronized lock must stay high before release (≥1)
- LOCK_TIMEOUT_CYCLES, 4096, maximum cycles spent in WAIT_LOCK per attempt (≥2)
- RELEASE_GAP, 8, cycles between chip_reset release and periph_reset release (≥1)
- MAX_RETRY, 3, number of re-attempts after the first failed attempt
- CNT_W, 16, width of the shared timer; must hold the largest cycle parameter
- RETRY_W, 2, width of retry_cnt; must hold MAX_RETRY

Ports:
- clk  in  1  free-running reference clock, never gated by the PLL
- reset  in  1  synchronous, active-high reset
- locked  in  1  PLL lock indication; asynchronous, goes through an internal 2-flop synchronizer
- sw_reset_req  in  1  synchronous level request to restart the sequence
- pll_areset  out  1  PLL reset, active-high
- chip_reset  out  1  core reset, active-high
- periph_reset  out  1  peripheral reset, active-high
- rst_done  out  1  high while the sequence is complete (state RUN)
- pll_fail  out  1  high in state FAIL
- retry_cnt  out  RETRY_W  number of retries used in the current sequence

Behaviour:
- One clock and one synchronous reset, as already decided.
- All outputs are registered and decoded from the current state.
- locked_s is the synchronized lock; it lags locked by 2 cycles.
- The synchronizer flops reset to 0.

Reset values (reset=1 on a clock edge):
- state=PLL_RST, timer=0, retry_cnt=0
- pll_areset=1, chip_reset=1, periph_reset=1, rst_done=0, pll_fail=0

States:
- PLL_RST: pll_areset=1, all resets=1. Stays exactly PLL_RST_CYCLES cycles, then goes to WAIT_LOCK with timer=0.
- WAIT_LOCK: pll_areset=0, resets=1.
  - locked_s=1 → STABLE with timer=0.
  - Timer reaches LOCK_TIMEOUT_CYCLES-1 without lock: if retry_cnt==MAX_RETRY → FAIL; else retry_cnt+1 → PLL_RST.
  - Lock seen on the timeout cycle wins over timeout.
- STABLE: resets=1.
  - locked_s=0 on any cycle → WAIT_LOCK with timer=0 (fresh timeout window, retry_cnt unchanged).
  - After exactly LOCK_STABLE_CYCLES cycles with locked_s=1 → REL_CHIP.
- REL_CHIP: chip_reset=0, periph_reset=1. Stays exactly RELEASE_GAP cycles, then goes to RUN.
- RUN: chip_reset=0, periph_reset=0, rst_done=1.
- FAIL: pll_areset=1, all resets=1, pll_fail=1. Stays until sw_reset_req or reset.

Priority on every edge (highest first):
- reset
- sw_reset_req: from any state → PLL_RST, retry_cnt=0, pll_fail cleared
- locked_s=0 in REL_CHIP or RUN → PLL_RST, retry_cnt=0, all resets re-asserted on the next edge
- timer/lock transitions listed above

Timer rules:
- The timer is cleared on every state change and saturates; it never wraps.
- retry_cnt saturates at MAX_RETRY.
- A held-high sw_reset_req keeps the block in PLL_RST with the timer cleared. The sequence proceeds only once the request drops.

Timing:
- Locked already high, defaults, cycle 0 = first edge with reset=0:
  - pll_areset falls at cycle 16
  - chip_reset falls at cycle 81
  - periph_reset falls and rst_done rises at cycle 89
- chip_reset never deasserts before the PLL has shown a stable lock.
- periph_reset is never 0 while chip_reset is 1.

Test Plan:
- Defaults, locked tied high, reset released → pll_areset 1→0 at cycle 16, chip_reset 1→0 at cycle 81, periph_reset and rst_done change at cycle 89, retry_cnt=0.
- locked never asserts → 4 attempts of 16+4096 cycles each; retry_cnt steps 1,2,3; pll_fail=1 at cycle 16448 with pll_areset=1. sw_reset_req then clears pll_fail and retry_cnt and restarts in PLL_RST.
- locked rises, drops for 1 cycle at STABLE count 40, rises again → returns to WAIT_LOCK, then STABLE restarts from 0. chip_reset stays 1 until 64 clean cycles have elapsed; retry_cnt unchanged.
- In RUN, locked falls → 2 cycles later state is PLL_RST with chip_reset=periph_reset=pll_areset=1 and rst_done=0. Full sequence repeats with retry_cnt=0.
- sw_reset_req pulsed 1 cycle during REL_CHIP and during WAIT_LOCK (retry_cnt=2) → PLL_RST on the next edge, retry_cnt=0, all resets asserted.
- reset asserted mid-STABLE for 1 cycle → all outputs return to reset values on that edge and the sequence restarts from cycle 0 timing.
